// File: rtl/vpm_pkg.sv
// Shared types and helpers for the multi-lane pipelined MAC: tree width,
// lane layout, stage sidebands, output-user bit positions and result clamping.
package vpm_pkg;

  localparam int unsigned LANE_DW  = 32;
  localparam int unsigned SAT_W    = 128;
  localparam int unsigned RES_W    = 64;
  localparam int unsigned OU_SAT   = 0;
  localparam int unsigned OU_BEATS = 1;
  localparam int unsigned OU_W     = 2;

  typedef struct packed {
    logic [LANE_DW-1:0] weight;
    logic [LANE_DW-1:0] activation;
  } lane_t;

  typedef struct packed {
    logic start;
    logic close;
    logic bias;
    logic beats;
  } side_t;

  typedef struct packed {
    logic             sat;
    logic [RES_W-1:0] value;
  } sat_res_t;

  function automatic int unsigned tree_w(input int unsigned dw, input int unsigned lanes);
    return 2 * dw + $clog2(lanes);
  endfunction

  // Clamp (or wrap) r to a signed dw-bit range, then optionally zero negatives.
  function automatic sat_res_t sat_relu(input logic signed [SAT_W-1:0] r,
                                        input int unsigned dw,
                                        input logic sat_en,
                                        input logic relu_en);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] v;
    sat_res_t res;
    hi      = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
    lo      = ~hi;
    res.sat = 1'b0;
    if (sat_en) begin
      if (r > hi) begin
        v       = hi;
        res.sat = 1'b1;
      end else if (r < lo) begin
        v       = lo;
        res.sat = 1'b1;
      end else begin
        v = r;
      end
    end else begin
      v = (r <<< (SAT_W - dw)) >>> (SAT_W - dw);
    end
    if (relu_en && v[SAT_W-1]) v = '0;
    res.value = v[RES_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/vpm_adder_tree.sv
// Combinational signed sum of LANES per-lane products, sign-extended to SW bits.
module vpm_adder_tree
  import vpm_pkg::*;
#(
  parameter int unsigned PW    = 64,
  parameter int unsigned LANES = 4,
  parameter int unsigned SW    = tree_w(PW / 2, LANES)
) (
  input  logic [LANES*PW-1:0] prod,
  output logic signed [SW-1:0] sum_c
);

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      sum_c = sum_c + SW'(signed'(prod[i*PW +: PW]));
    end
  end

endmodule

// File: rtl/vec_pipe_mac.sv
// Multi-lane fixed-point MAC: S0 input, S1 products, S2 tree sum, S3 accumulate
// and output. One rounded-down result per packet on an AXI-Stream master.
module vec_pipe_mac
  import vpm_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned FRAC     = 16,
  parameter int unsigned LANES    = 4,
  parameter int unsigned GUARD    = 8,
  parameter int unsigned IDW      = 8,
  parameter int unsigned BEATS    = 0,
  parameter int unsigned SATURATE = 1,
  parameter int unsigned RELU     = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [LANES*2*DW-1:0] saxis_tdata,
  input  logic                  saxis_tvalid,
  output logic                  saxis_tready,
  input  logic                  saxis_tlast,
  input  logic                  saxis_tuser,
  input  logic [IDW-1:0]        saxis_tid,
  output logic [DW-1:0]         maxis_tdata,
  output logic                  maxis_tvalid,
  input  logic                  maxis_tready,
  output logic                  maxis_tlast,
  output logic [IDW-1:0]        maxis_tid,
  output logic [OU_W-1:0]       maxis_tuser
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned SW = tree_w(DW, LANES);
  localparam int unsigned AW = 2 * DW + GUARD;
  localparam int unsigned CW = $clog2(BEATS + 2);
  localparam int unsigned BW = LANES * 2 * DW;

  logic                 en_c, accept_c, cnt_hit_c;
  logic [CW-1:0]        cnt_inc_c;
  side_t                in_side_c;
  logic signed [SW-1:0] tree_sum_c;
  logic signed [AW-1:0] acc_next_c;
  sat_res_t             sat_c;

  logic                 rdy_q, rdy_d, in_pkt_q, in_pkt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [BW-1:0]        s0_data_q, s0_data_d;
  logic [LANES*PW-1:0]  s1_prod_q, s1_prod_d;
  logic signed [SW-1:0] s2_sum_q, s2_sum_d;
  side_t                s0_side_q, s0_side_d, s1_side_q, s1_side_d, s2_side_q, s2_side_d;
  logic [IDW-1:0]       s0_tid_q, s0_tid_d, s1_tid_q, s1_tid_d, s2_tid_q, s2_tid_d;
  logic signed [DW-1:0] s1_bact_q, s1_bact_d, s2_bact_q, s2_bact_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 m_valid_q, m_valid_d;
  logic [DW-1:0]        m_data_q, m_data_d;
  logic [IDW-1:0]       m_tid_q, m_tid_d;
  logic [OU_W-1:0]      m_user_q, m_user_d;

  vpm_adder_tree #(.PW(PW), .LANES(LANES), .SW(SW)) u_tree (
    .prod  (s1_prod_q),
    .sum_c (tree_sum_c)
  );

  // Packet framing, stage advance and result formation.
  always_comb begin
    rdy_d      = 1'b1;
    in_pkt_d   = in_pkt_q;
    cnt_d      = cnt_q;
    s0_valid_d = s0_valid_q;
    s0_data_d  = s0_data_q;
    s0_side_d  = s0_side_q;
    s0_tid_d   = s0_tid_q;
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_side_d  = s1_side_q;
    s1_tid_d   = s1_tid_q;
    s1_bact_d  = s1_bact_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_side_d  = s2_side_q;
    s2_tid_d   = s2_tid_q;
    s2_bact_d  = s2_bact_q;
    acc_d      = acc_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_tid_d    = m_tid_q;
    m_user_d   = m_user_q;

    en_c      = !m_valid_q || maxis_tready;
    accept_c  = saxis_tvalid && en_c && rdy_q;
    cnt_inc_c = cnt_q + CW'(1);
    cnt_hit_c = (BEATS != 0) && (cnt_inc_c == CW'(BEATS));

    in_side_c.start = !in_pkt_q;
    in_side_c.close = saxis_tlast || cnt_hit_c;
    in_side_c.bias  = !in_pkt_q && saxis_tuser;
    in_side_c.beats = cnt_hit_c && !saxis_tlast;

    if (accept_c) begin
      if (in_side_c.close) begin
        cnt_d    = '0;
        in_pkt_d = 1'b0;
      end else begin
        cnt_d    = cnt_inc_c;
        in_pkt_d = 1'b1;
      end
    end

    // Bias beats load lane-0 activation aligned to the product fraction.
    if (s2_side_q.bias) begin
      acc_next_c = AW'(s2_bact_q) <<< FRAC;
    end else if (s2_side_q.start) begin
      acc_next_c = AW'(s2_sum_q);
    end else begin
      acc_next_c = acc_q + AW'(s2_sum_q);
    end
    sat_c = sat_relu(SAT_W'(acc_next_c) >>> FRAC, DW, SATURATE != 0, RELU != 0);

    if (en_c) begin
      s0_valid_d = accept_c;
      s0_data_d  = saxis_tdata;
      s0_side_d  = in_side_c;
      s0_tid_d   = saxis_tid;

      s1_valid_d = s0_valid_q;
      s1_side_d  = s0_side_q;
      s1_tid_d   = s0_tid_q;
      s1_bact_d  = s0_data_q[DW-1:0];
      for (int i = 0; i < int'(LANES); i++) begin
        s1_prod_d[i*PW +: PW] = PW'(signed'(s0_data_q[i*2*DW+DW +: DW]))
                              * PW'(signed'(s0_data_q[i*2*DW +: DW]));
      end

      s2_valid_d = s1_valid_q;
      s2_sum_d   = tree_sum_c;
      s2_side_d  = s1_side_q;
      s2_tid_d   = s1_tid_q;
      s2_bact_d  = s1_bact_q;

      m_valid_d = 1'b0;
      if (s2_valid_q) begin
        acc_d = acc_next_c;
        if (s2_side_q.close) begin
          m_valid_d          = 1'b1;
          m_data_d           = DW'(sat_c.value);
          m_tid_d            = s2_tid_q;
          m_user_d[OU_SAT]   = sat_c.sat;
          m_user_d[OU_BEATS] = s2_side_q.beats;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_q      <= 1'b0;
      in_pkt_q   <= 1'b0;
      cnt_q      <= '0;
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
      s0_side_q  <= '0;
      s0_tid_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_side_q  <= '0;
      s1_tid_q   <= '0;
      s1_bact_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_side_q  <= '0;
      s2_tid_q   <= '0;
      s2_bact_q  <= '0;
      acc_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_tid_q    <= '0;
      m_user_q   <= '0;
    end else begin
      rdy_q      <= rdy_d;
      in_pkt_q   <= in_pkt_d;
      cnt_q      <= cnt_d;
      s0_valid_q <= s0_valid_d;
      s0_data_q  <= s0_data_d;
      s0_side_q  <= s0_side_d;
      s0_tid_q   <= s0_tid_d;
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_side_q  <= s1_side_d;
      s1_tid_q   <= s1_tid_d;
      s1_bact_q  <= s1_bact_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_side_q  <= s2_side_d;
      s2_tid_q   <= s2_tid_d;
      s2_bact_q  <= s2_bact_d;
      acc_q      <= acc_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_tid_q    <= m_tid_d;
      m_user_q   <= m_user_d;
    end
  end

  assign saxis_tready = en_c && rdy_q;
  assign maxis_tdata  = m_data_q;
  assign maxis_tvalid = m_valid_q;
  assign maxis_tlast  = m_valid_q;
  assign maxis_tid    = m_tid_q;
  assign maxis_tuser  = m_user_q;

endmodule

// File: tb/tb_vec_pipe_mac.sv
// Scoreboard bench for vec_pipe_mac: three instances (default, RELU=1, BEATS=3)
// driven with directed Q16.16 vectors; a monitor pops expected results per handshake.
module tb_vec_pipe_mac;
  import vpm_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned LANES = 4;
  localparam int unsigned IDW   = 8;
  localparam int unsigned ND    = 3;
  localparam int unsigned BW    = LANES * 2 * DW;

  typedef struct {
    logic [DW-1:0]  data;
    logic [IDW-1:0] tid;
    logic [1:0]     user;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;

  logic [BW-1:0]  s_data  [ND];
  logic           s_valid [ND];
  logic           s_ready [ND];
  logic           s_last  [ND];
  logic           s_user  [ND];
  logic [IDW-1:0] s_tid   [ND];
  logic [DW-1:0]  m_data  [ND];
  logic           m_valid [ND];
  logic           m_ready [ND];
  logic           m_last  [ND];
  logic [IDW-1:0] m_tid   [ND];
  logic [1:0]     m_user  [ND];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < int'(ND); g++) begin : g_dut
    vec_pipe_mac #(
      .DW(DW), .FRAC(16), .LANES(LANES), .GUARD(8), .IDW(IDW),
      .BEATS(g == 2 ? 3 : 0), .SATURATE(1), .RELU(g == 1 ? 1 : 0)
    ) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .saxis_tdata  (s_data[g]),
      .saxis_tvalid (s_valid[g]),
      .saxis_tready (s_ready[g]),
      .saxis_tlast  (s_last[g]),
      .saxis_tuser  (s_user[g]),
      .saxis_tid    (s_tid[g]),
      .maxis_tdata  (m_data[g]),
      .maxis_tvalid (m_valid[g]),
      .maxis_tready (m_ready[g]),
      .maxis_tlast  (m_last[g]),
      .maxis_tid    (m_tid[g]),
      .maxis_tuser  (m_user[g])
    );
  end

  function automatic logic [BW-1:0] beat(input logic [DW-1:0] w, input logic [DW-1:0] a,
                                         input bit all_lanes);
    lane_t l;
    logic [BW-1:0] b;
    b = '0;
    l.weight     = w;
    l.activation = a;
    for (int i = 0; i < int'(LANES); i++)
      if (all_lanes || i == 0) b[i*2*DW +: 2*DW] = l;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int d, input logic [DW-1:0] data, input logic [IDW-1:0] tid,
                      input logic [1:0] user);
    exp_t e;
    e.data = data;
    e.tid  = tid;
    e.user = user;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon_pop(input int d);
    exp_t e;
    int n;
    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_unexpected: got data 0x%08h tid 0x%02h, required no output",
               d, m_data[d], m_tid[d]);
      return;
    end
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    chk($sformatf("dut%0d_data tid 0x%02h", d, e.tid), 64'(m_data[d]), 64'(e.data));
    chk($sformatf("dut%0d_tid", d), 64'(m_tid[d]), 64'(e.tid));
    chk($sformatf("dut%0d_tuser tid 0x%02h", d, e.tid), 64'(m_user[d]), 64'(e.user));
    chk($sformatf("dut%0d_tlast", d), 64'(m_last[d]), 64'd1);
  endtask

  // Monitor: one pop per output handshake, sampled mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < int'(ND); d++)
      if (rstn && m_valid[d] && m_ready[d]) mon_pop(d);
  end

  task automatic send(input int d, input logic [BW-1:0] data, input logic last,
                      input logic user, input logic [IDW-1:0] tid);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    s_data[d]  = data;
    s_last[d]  = last;
    s_user[d]  = user;
    s_tid[d]   = tid;
    s_valid[d] = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = s_ready[d];
      @(posedge clk);
      #1;
      n++;
    end
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
    s_user[d]  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_send_timeout tid 0x%02h: accepted 0, required 1 within %0d cycles",
               d, tid, n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle(3);
    for (int d = 0; d < int'(ND); d++) begin
      chk($sformatf("dut%0d_rst_tready", d), 64'(s_ready[d]), 64'd0);
      chk($sformatf("dut%0d_rst_tvalid", d), 64'(m_valid[d]), 64'd0);
      chk($sformatf("dut%0d_rst_tdata", d), 64'(m_data[d]), 64'd0);
      chk($sformatf("dut%0d_rst_tuser", d), 64'({m_tid[d], m_user[d]}), 64'd0);
    end
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      idle(1);
      n++;
    end
    chk("drain_pending", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BW-1:0]  bx;
    logic [DW-1:0]  snap_d;
    logic [IDW-1:0] snap_t;
    logic [1:0]     snap_u;
    int lat;
    bx = beat(32'h00012000, 32'h00024000, 1'b1);
    for (int d = 0; d < int'(ND); d++) begin
      s_data[d]  = '0;
      s_valid[d] = 1'b0;
      s_last[d]  = 1'b0;
      s_user[d]  = 1'b0;
      s_tid[d]   = '0;
      m_ready[d] = 1'b1;
    end
    rstn = 1'b0;
    idle(1);
    do_reset();

    // Single beat, all lanes, with latency measurement.
    push(0, 32'h000A2000, 8'h11, 2'b00);
    send(0, bx, 1'b1, 1'b0, 8'h11);
    lat = 0;
    while (!m_valid[0] && lat < 10) begin
      idle(1);
      lat++;
    end
    chk("latency_cycles", 64'(lat), 64'd3);
    push(1, 32'h000A2000, 8'h12, 2'b00);
    send(1, bx, 1'b1, 1'b0, 8'h12);
    push(2, 32'h000A2000, 8'h13, 2'b00);
    send(2, bx, 1'b1, 1'b0, 8'h13);

    // Ten-beat packet with random gaps.
    push(0, 32'h00654000, 8'h29, 2'b00);
    for (int k = 0; k < 10; k++) begin
      send(0, bx, k == 9, 1'b0, 8'(8'h20 + k));
      idle($urandom_range(0, 2));
    end

    // Bias beat then product beat; bias-only packet.
    push(0, 32'h00038800, 8'h33, 2'b00);
    send(0, beat(32'h00012000, 32'h00010000, 1'b1), 1'b0, 1'b1, 8'h30);
    send(0, beat(32'h00012000, 32'h00024000, 1'b0), 1'b1, 1'b0, 8'h33);
    push(0, 32'h00010000, 8'h34, 2'b00);
    send(0, beat(32'h00012000, 32'h00010000, 1'b1), 1'b1, 1'b1, 8'h34);

    // Saturation, floor rounding and ReLU.
    push(0, 32'h7FFFFFFF, 8'h40, 2'b01);
    send(0, beat(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1), 1'b1, 1'b0, 8'h40);
    push(0, 32'h80000000, 8'h41, 2'b01);
    send(0, beat(32'h80000000, 32'h7FFFFFFF, 1'b1), 1'b1, 1'b0, 8'h41);
    push(0, 32'hFFFC0000, 8'h45, 2'b00);
    send(0, beat(32'hFFFF0000, 32'h00010000, 1'b1), 1'b1, 1'b0, 8'h45);
    push(0, 32'hFFFFFFFF, 8'h46, 2'b00);
    send(0, beat(32'hFFFFFFFF, 32'h00008000, 1'b0), 1'b1, 1'b0, 8'h46);
    push(1, 32'h00000000, 8'h42, 2'b01);
    send(1, beat(32'h80000000, 32'h7FFFFFFF, 1'b1), 1'b1, 1'b0, 8'h42);
    push(1, 32'h7FFFFFFF, 8'h43, 2'b01);
    send(1, beat(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1), 1'b1, 1'b0, 8'h43);
    push(1, 32'h00000000, 8'h44, 2'b00);
    send(1, beat(32'hFFFF0000, 32'h00010000, 1'b1), 1'b1, 1'b0, 8'h44);
    drain();

    // Output stall with a second packet queued behind it.
    m_ready[0] = 1'b0;
    push(0, 32'h000A2000, 8'h51, 2'b00);
    push(0, 32'h00028800, 8'h52, 2'b00);
    send(0, bx, 1'b1, 1'b0, 8'h51);
    send(0, beat(32'h00012000, 32'h00024000, 1'b0), 1'b1, 1'b0, 8'h52);
    lat = 0;
    while (!m_valid[0] && lat < 10) begin
      idle(1);
      lat++;
    end
    snap_d = m_data[0];
    snap_t = m_tid[0];
    snap_u = m_user[0];
    for (int k = 0; k < 5; k++) begin
      idle(1);
      chk("stall_saxis_tready", 64'(s_ready[0]), 64'd0);
      chk("stall_tvalid", 64'(m_valid[0]), 64'd1);
      chk("stall_tdata", 64'(m_data[0]), 64'(snap_d));
      chk("stall_tid_tuser", 64'({m_tid[0], m_user[0]}), 64'({snap_t, snap_u}));
    end
    m_ready[0] = 1'b1;
    idle(1);
    chk("b2b_tvalid", 64'(m_valid[0]), 64'd1);
    chk("b2b_tid", 64'(m_tid[0]), 64'h52);
    drain();

    // Beat-count close, with and without a coincident tlast.
    push(2, 32'h001E6000, 8'h63, 2'b10);
    for (int k = 0; k < 3; k++) send(2, bx, 1'b0, 1'b0, 8'(8'h61 + k));
    push(2, 32'h001E6000, 8'h66, 2'b00);
    send(2, bx, 1'b0, 1'b0, 8'h64);
    send(2, bx, 1'b0, 1'b0, 8'h65);
    send(2, bx, 1'b1, 1'b0, 8'h66);
    drain();

    // Reset mid-packet discards the partial packet and beat count.
    send(2, bx, 1'b0, 1'b0, 8'h70);
    send(2, bx, 1'b0, 1'b0, 8'h71);
    idle(1);
    do_reset();
    push(2, 32'h000A2000, 8'h72, 2'b00);
    send(2, bx, 1'b1, 1'b0, 8'h72);
    drain();
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_pipe_mac.md
# vec_pipe_mac

Parametrised multi-lane pipelined fixed-point MAC for the convolution datapath. Each input beat carries LANES {weight, activation} pairs. The block multiplies every lane, sums the products through an adder tree, and accumulates across the beats of a packet. At packet end it emits one rounded-down, optionally saturated and ReLU'd, DW-bit result on an AXI-Stream master. It generalises the single-lane pipe_mac with lane count, fractional-point position, saturation, ReLU, and a beat-count packet close.

## Interface
- DW, 32, data width of weight, activation and result (signed fixed point)
- FRAC, 16, fractional bits of every operand and of the result
- LANES, 4, parallel multiply lanes (power of two, 1..16)
- GUARD, 8, extra accumulator MSBs
- IDW, 8, tid width
- BEATS, 0, maximum beats per packet; 0 = close on tlast only
- SATURATE, 1, 1 = clamp result to the DW range; 0 = truncate (wrap)
- RELU, 0, 1 = negative results forced to 0
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- saxis_tdata  in  LANES*2*DW  lane i at [i*2DW +: 2DW] = {weight, activation}
- saxis_tvalid  in  1  input beat valid
- saxis_tready  out  1  input beat accepted when high with tvalid
- saxis_tlast  in  1  last beat of packet
- saxis_tuser  in  1  on the first beat of a packet: bias beat
- saxis_tid  in  IDW  packet id
- maxis_tdata  out  DW  result
- maxis_tvalid  out  1  result valid
- maxis_tready  in  1  downstream ready
- maxis_tlast  out  1  always 1 when maxis_tvalid is high (one beat per packet)
- maxis_tid  out  IDW  tid of the packet's closing beat
- maxis_tuser  out  2  [0] saturation occurred; [1] packet closed by BEATS without tlast

## Operation
- Products: signed DW×DW→2DW per lane, 2·FRAC fractional bits.
- Tree sum: width 2DW+clog2(LANES).
- Accumulator: signed, AW=2DW+GUARD bits; wraps on overflow.
- Packet start: the first accepted beat after reset or after a closing beat.
- Bias beat: a start beat with tuser=1.
  - Accumulator loads lane-0 activation, sign-extended and shifted left by FRAC.
  - No products from that beat are added.
- Any other start beat: accumulator = tree sum. Later beats: accumulator += tree sum.
- Closing beat: tlast=1, or the beat-counter reaches BEATS when BEATS>0.
  - Either condition closes the packet. A beat with both tlast and the count condition sets tuser[1]=0.
  - The beat counter resets to 0 on every close.
- Result formation: r = final_accum >>> FRAC (arithmetic shift, floor).
  - SATURATE=1: r above 2^(DW-1)-1 → 0x7FFF_FFFF; r below -2^(DW-1) → 0x8000_0000; either case sets tuser[0].
  - SATURATE=0: take the low DW bits; tuser[0]=0.
  - RELU=1: a negative result becomes 0, applied after saturation.
- A bias beat that is also the closing beat outputs the bias itself.

## Timing
- Pipeline: S0 input register, S1 per-lane product register, S2 tree-sum register, S3 accumulate plus output register.
- Every stage carries a valid bit and the start, close, bias and tid sidebands.
- Latency: when the closing beat is accepted at edge E, maxis_tvalid is high after edge E+3, if there is no stall.
- Global enable: en = !maxis_tvalid | maxis_tready. All stages advance only when en=1.
- saxis_tready = en & rdy_q.
  - rdy_q is a flop cleared by reset and set on the first clk after rstn deasserts.
  - saxis_tready is 0 during reset.
- Back-to-back packets are accepted at full rate. Bubbles (tvalid=0) advance as invalid stages.
- While maxis_tvalid=1 and maxis_tready=0: maxis_* outputs hold stable and no input is accepted.
- Simultaneous output handshake and new result arriving in S3: the output register reloads and maxis_tvalid stays 1.
- Reset value of every output is 0. Reset asserted mid-packet:
  - the partial packet and all stage contents are discarded;
  - the beat counter and accumulator return to 0;
  - the next accepted beat is a packet start.

## Structure
- Package vpm_pkg holds:
  - a width function for the tree (2DW+clog2(LANES));
  - the lane slice typedef {weight, activation};
  - a saturate-and-ReLU function (sign, range check, clamp);
  - the out_user bit indices as localparams.
- Sub-module vpm_adder_tree: combinational signed sum of LANES products, instantiated ahead of the S2 register.

## Test plan
All values are Q16.16 unless stated.
- LANES=4, one beat with every lane (0x00012000, 0x00024000) and tlast=1 → maxis_tdata 0x000A2000, tid echoed, tuser 0, tvalid high 3 cycles after acceptance.
- 10 identical beats from the first case, tlast on the 10th, tvalid toggled randomly between beats → 0x00654000.
- Bias beat with lane0 activation 0x00010000, then one beat with lane0 (0x00012000, 0x00024000), other lanes 0, tlast → 0x00038800. A bias beat alone with tlast → 0x00010000.
- All lanes (0x7FFFFFFF, 0x7FFFFFFF), one beat:
  - SATURATE=1 → 0x7FFFFFFF, tuser[0]=1;
  - weights 0x80000000, activations 0x7FFFFFFF → 0x80000000, tuser[0]=1;
  - same with RELU=1 → 0x00000000.
- Result pending with maxis_tready low for 5 cycles:
  - saxis_tready stays 0 and maxis_* stay stable;
  - on release, two queued single-beat packets emit on consecutive handshakes without loss.
- BEATS=3 with no tlast, 3 beats of the first case → 0x001E6000, tuser[1]=1. Then rstn pulsed after 2 beats of a new packet, followed by one beat with tlast → 0x000A2000.
